// File: rtl/imem_loader.sv
// imem_loader: host-side writer for the byte-wide instruction memory.
// Takes 32-bit words from a valid/ready stream and writes each one as four big-endian
// bytes (one per cycle) starting at a word-aligned base address. The datapath is held in
// reset (cpu_reset_o low) until a load finishes cleanly.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds checksum_o, the mod-2^32 sum of the
// words accepted since the last accepted start.
module imem_loader #(
  parameter int unsigned MemBytes = 101,
  parameter int unsigned AddrW    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [AddrW-1:0] base_addr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_data_i,
  input  logic             in_last_i,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [7:0]       mem_wdata_o,
  output logic             cpu_reset_o,
  output logic             done_o,
  output logic             error_o
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]      checksum_o
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitWord,
    StWrite,
    StDone,
    StErr
  } state_e;

  // Highest legal byte address, widened so the end-of-word compare cannot wrap.
  localparam logic [AddrW:0] LastByte = (AddrW + 1)'(MemBytes - 1);

  state_e           state_q;
  logic [AddrW-1:0] addr_q;
  logic [1:0]       k_q;
  logic [31:0]      word_q;
  logic             last_q;
  logic             in_ready_q;
  logic             mem_we_q;
  logic [AddrW-1:0] mem_addr_q;
  logic [7:0]       mem_wdata_q;
  logic             cpu_reset_q;
  logic             done_q;
  logic             error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      checksum_q;
`endif

  logic             start_aligned;
  logic             go_load;
  logic             go_err;
  logic             accept;
  logic             overflow;
  logic [AddrW:0]   word_end;
  logic [AddrW-1:0] byte_addr;
  logic [7:0]       byte_sel;

  // Decode start handling, word acceptance, overflow and the current big-endian byte.
  always_comb begin
    start_aligned = start_i && (base_addr_i[1:0] == 2'b00);
    // A start is honoured only when no load is in flight.
    go_load  = start_aligned && (state_q inside {StIdle, StDone, StErr});
    go_err   = start_i && !start_aligned && (state_q inside {StIdle, StDone});
    accept   = (state_q == StWaitWord) && in_ready_q && in_valid_i;
    word_end = {1'b0, addr_q} + (AddrW + 1)'(3);
    overflow = word_end > LastByte;
    byte_addr = addr_q + AddrW'(k_q);
    byte_sel  = 8'h00;
    unique case (k_q)
      2'd0: byte_sel = word_q[31:24];
      2'd1: byte_sel = word_q[23:16];
      2'd2: byte_sel = word_q[15:8];
      2'd3: byte_sel = word_q[7:0];
      default: byte_sel = 8'h00;
    endcase
  end

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      k_q         <= '0;
      word_q      <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      if (go_load) begin
        state_q     <= StWaitWord;
        addr_q      <= base_addr_i;
        in_ready_q  <= 1'b1;
        cpu_reset_q <= 1'b0;
        done_q      <= 1'b0;
        error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        checksum_q  <= '0;
`endif
      end else if (go_err) begin
        state_q     <= StErr;
        in_ready_q  <= 1'b0;
        cpu_reset_q <= 1'b0;
        done_q      <= 1'b0;
        error_q     <= 1'b1;
      end else begin
        unique case (state_q)
          StWaitWord: begin
            if (accept) begin
              word_q     <= in_data_i;
              last_q     <= in_last_i;
              in_ready_q <= 1'b0;
              k_q        <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              checksum_q <= checksum_q + in_data_i;
`endif
              if (overflow) begin
                // The whole word is rejected: none of its bytes reach memory.
                state_q <= StErr;
                error_q <= 1'b1;
              end else begin
                state_q <= StWrite;
              end
            end
          end
          StWrite: begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= byte_addr;
            mem_wdata_q <= byte_sel;
            k_q         <= k_q + 2'd1;
            if (k_q == 2'd3) begin
              addr_q <= addr_q + AddrW'(4);
              if (last_q) begin
                state_q     <= StDone;
                done_q      <= 1'b1;
                cpu_reset_q <= 1'b1;
              end else begin
                state_q    <= StWaitWord;
                in_ready_q <= 1'b1;
              end
            end
          end
          StIdle, StDone, StErr: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign cpu_reset_o = cpu_reset_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum_o  = checksum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios plus randomized loads, checked against an
// expected write log and memory image built from the load rules with plain arithmetic.
module tb_imem_loader;
  localparam int unsigned MemBytes = 101;
  localparam int unsigned AddrW    = 32;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             start_i;
  logic [AddrW-1:0] base_addr_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      in_data_i;
  logic             in_last_i;
  logic             mem_we_o;
  logic [AddrW-1:0] mem_addr_o;
  logic [7:0]       mem_wdata_o;
  logic             cpu_reset_o;
  logic             done_o;
  logic             error_o;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      checksum_o;
`endif

  imem_loader #(
    .MemBytes(MemBytes),
    .AddrW   (AddrW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_last_i  (in_last_i),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .cpu_reset_o(cpu_reset_o),
    .done_o     (done_o),
    .error_o    (error_o)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum_o (checksum_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [7:0]  obs_mem[MemBytes];
  logic [7:0]  exp_mem[MemBytes];
  int unsigned oob_writes = 0;
  logic [31:0] sum_model = '0;
  logic [31:0] wbuf[8];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Log every byte write seen on the memory port.
  always @(negedge clk) begin
    if (mem_we_o === 1'b1) begin
      obs_q.push_back(wr_t'{cyc: cyc, addr: mem_addr_o, data: mem_wdata_o});
      if (mem_addr_o < MemBytes) obs_mem[mem_addr_o] = mem_wdata_o;
      else oob_writes++;
    end
  end

  task automatic expect_word(input logic [31:0] a, input logic [31:0] w,
                             input int unsigned c, input int nbytes);
    logic [31:0] sh;
    for (int k = 0; k < nbytes; k++) begin
      sh = w >> (24 - 8 * k);
      exp_q.push_back(wr_t'{cyc: c + 1 + k, addr: a + k, data: sh[7:0]});
      exp_mem[a + k] = sh[7:0];
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) check({tag, "_wr"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, in_ready_o, 1'b0);
    check({tag, "_we"}, mem_we_o, 1'b0);
    check({tag, "_addr"}, mem_addr_o, 0);
    check({tag, "_wdata"}, mem_wdata_o, 0);
    check({tag, "_cpurst"}, cpu_reset_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_err"}, error_o, 1'b0);
  endtask

  task automatic do_start(input logic [31:0] b);
    start_i     = 1'b1;
    base_addr_i = b;
    @(negedge clk);
    start_i     = 1'b0;
    base_addr_i = $urandom;
    if (b[1:0] == 2'b00) sum_model = '0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, output bit acc);
    acc        = 1'b0;
    in_data_i  = d;
    in_last_i  = l;
    in_valid_i = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (in_ready_o) begin
        @(negedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid_i = 1'b0;
  endtask

  // One complete load of wbuf[0..nw-1] at base, with its expected consequences.
  task automatic run_load(input logic [31:0] base, input int nw);
    bit          acc;
    bit          last;
    int          cnt;
    int unsigned c;
    logic [31:0] a;
    do_start(base);
    if (base[1:0] != 2'b00) begin
      check("misalign_err", error_o, 1'b1);
      check("misalign_rdy", in_ready_o, 1'b0);
      check("misalign_cpurst", cpu_reset_o, 1'b0);
      repeat (3) @(negedge clk);
      check("misalign_stay", error_o, 1'b1);
    end else begin
      check("start_rdy", in_ready_o, 1'b1);
      check("start_done", done_o, 1'b0);
      check("start_err", error_o, 1'b0);
      check("start_cpurst", cpu_reset_o, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("cksum_clear", checksum_o, 0);
`endif
      for (int i = 0; i < nw; i++) begin
        last = (i == nw - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_word(wbuf[i], last, acc);
        check("accept", acc, 1'b1);
        if (!acc) break;
        c = cyc;
        sum_model += wbuf[i];
        a = base + 4 * i;
        if (a + 3 > MemBytes - 1) begin
          check("ovf_err", error_o, 1'b1);
          check("ovf_rdy", in_ready_o, 1'b0);
          check("ovf_cpurst", cpu_reset_o, 1'b0);
          break;
        end
        expect_word(a, wbuf[i], c, 4);
        if (!last) begin
          // Offer the next word and stray starts while busy; neither may take effect.
          in_data_i  = wbuf[i + 1];
          in_last_i  = (i + 1 == nw - 1);
          in_valid_i = 1'($urandom_range(0, 1));
          cnt = 0;
          while (!in_ready_o && cnt < 10) begin
            start_i     = 1'($urandom_range(0, 1));
            base_addr_i = $urandom;
            cnt++;
            @(negedge clk);
          end
          start_i    = 1'b0;
          in_valid_i = 1'b0;
          check("ready_low", cnt, 4);
        end else begin
          repeat (4) @(negedge clk);
          check("done", done_o, 1'b1);
          check("cpu_reset", cpu_reset_o, 1'b1);
          check("rdy_after_last", in_ready_o, 1'b0);
        end
      end
    end
    repeat (2) @(negedge clk);
    compare_writes("load");
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("checksum", checksum_o, sum_model);
`endif
  endtask

  initial begin
    bit          acc;
    int unsigned c;
    int          diffs;
    logic [31:0] b;
    for (int i = 0; i < MemBytes; i++) begin
      obs_mem[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    rst_ni = 1'b0; start_i = 1'b0; base_addr_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    @(negedge clk);

    // Single word load.
    wbuf[0] = 32'h8D61000C;
    run_load(32'd0, 1);
    // Four-word program.
    wbuf[0] = 32'h8D61000C; wbuf[1] = 32'h39030008;
    wbuf[2] = 32'h00271022; wbuf[3] = 32'h08000014;
    run_load(32'd0, 4);
    // Misaligned base.
    run_load(32'd2, 0);
    // Second word would run past the last byte.
    wbuf[0] = 32'h11223344; wbuf[1] = 32'h55667788;
    run_load(32'd96, 2);

    // Reset while the second byte of a word is on the bus.
    do_start(32'd8);
    send_word(32'hCAFEF00D, 1'b0, acc);
    check("rst_accept", acc, 1'b1);
    c = cyc;
    expect_word(32'd8, 32'hCAFEF00D, c, 2);
    repeat (2) @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst_ni = 1'b1;
    sum_model = '0;
    @(negedge clk);
    compare_writes("rst_abort");
    wbuf[0] = 32'h00652022;
    run_load(32'd48, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    wbuf[0] = 32'h00000001; wbuf[1] = 32'hFFFFFFFF;
    run_load(32'd0, 2);
    check("cksum_wrap", checksum_o, 0);
`endif

    // Randomized loads, occasionally misaligned or running off the end.
    for (int n = 0; n < 15; n++) begin
      b = $urandom_range(0, MemBytes - 1);
      if ($urandom_range(0, 5) != 0) b = b & ~32'd3;
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      run_load(b, $urandom_range(1, 6));
    end

    diffs = 0;
    for (int i = 0; i < MemBytes; i++) if (obs_mem[i] !== exp_mem[i]) diffs++;
    check("mem_image", diffs, 0);
    check("oob_writes", oob_writes, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
